// File: rtl/systolic_sched_if.sv
// Operand-buffer / array-edge bundle for systolic_sched: tile control, joined A/B beat
// handshake, skewed array edge operands, per-PE strobes and status.
interface systolic_sched_if #(parameter int N = 2);
    logic             start;
    logic [7:0]       k_len;
    logic             a_valid;
    logic             a_ready;
    logic [8*N-1:0]   a_data;
    logic             b_valid;
    logic             b_ready;
    logic [8*N-1:0]   b_data;
    logic [8*N-1:0]   arr_a;
    logic [8*N-1:0]   arr_b;
    logic [N*N-1:0]   arr_clear;
    logic [N*N-1:0]   arr_cap;
    logic             busy;
    logic             done;
    logic             err;
    logic [15:0]      perf_stall;

    modport master (
        output start, k_len, a_valid, a_data, b_valid, b_data,
        input  a_ready, b_ready, arr_a, arr_b, arr_clear, arr_cap,
               busy, done, err, perf_stall
    );

    modport slave (
        input  start, k_len, a_valid, a_data, b_valid, b_data,
        output a_ready, b_ready, arr_a, arr_b, arr_clear, arr_cap,
               busy, done, err, perf_stall
    );
endinterface

// File: rtl/systolic_sched.sv
// Tile sequencer for an NxN systolic MAC array: joined A/B beat intake, diagonal edge skew,
// per-PE clear/capture strobes. Optional FEED-stall counter built when SYSTOLIC_SCHED_PERF_EN is defined.
module systolic_sched #(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst,
    systolic_sched_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start
    // FEED  | accepting K joined A/B beats
    // DRAIN | letting the last beat ripple to PE(N-1,N-1), then done
    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    localparam int         TAPS       = 2*N - 1;
    localparam logic [4:0] DRAIN_LOAD = 5'(2*N - 2);

    state_t     state, state_nxt;
    logic [7:0] k_q;
    logic [7:0] beat_cnt;
    logic [4:0] drain_cnt;
    logic       fire, accept, reject, drain_tc;
    logic       tag_first, tag_last;
    logic       a_rdy, b_rdy;
    logic       busy_q, done_q, err_q;
    logic [TAPS-1:0] first_dl, last_dl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        drain_tc  = 1'b0;
        tag_first = 1'b0;
        tag_last  = 1'b0;
        a_rdy     = 1'b0;
        b_rdy     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.k_len != 8'd0) begin
                        accept    = 1'b1;
                        state_nxt = FEED;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            FEED: begin
                // Cross-coupled readies so A and B are only ever consumed together.
                a_rdy     = bus.b_valid;
                b_rdy     = bus.a_valid;
                fire      = bus.a_valid & bus.b_valid;
                tag_first = fire && (beat_cnt == 8'd0);
                tag_last  = fire && (beat_cnt == k_q - 8'd1);
                if (tag_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                drain_tc = (drain_cnt == 5'd0);
                if (drain_tc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q       <= 8'd0;
            beat_cnt  <= 8'd0;
            drain_cnt <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= drain_tc;
            err_q  <= reject;
            if (accept) begin
                k_q      <= bus.k_len;
                beat_cnt <= 8'd0;
            end else if (fire) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (tag_last)            drain_cnt <= DRAIN_LOAD;
            else if (state == DRAIN) drain_cnt <= drain_cnt - 5'd1;
        end
    end

    // Tap 0 is the issue register; tap d reaches every PE with i+j == d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_dl <= '0;
            last_dl  <= '0;
        end else begin
            first_dl <= {first_dl[TAPS-2:0], tag_first};
            last_dl  <= {last_dl[TAPS-2:0], tag_last};
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_edge
        logic [7:0] a_dl [0:i];
        logic [7:0] b_dl [0:i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int d = 0; d <= i; d++) begin
                    a_dl[d] <= 8'h00;
                    b_dl[d] <= 8'h00;
                end
            end else begin
                a_dl[0] <= fire ? bus.a_data[8*i +: 8] : 8'h00;
                b_dl[0] <= fire ? bus.b_data[8*i +: 8] : 8'h00;
                for (int d = 1; d <= i; d++) begin
                    a_dl[d] <= a_dl[d-1];
                    b_dl[d] <= b_dl[d-1];
                end
            end
        end

        assign bus.arr_a[8*i +: 8] = a_dl[i];
        assign bus.arr_b[8*i +: 8] = b_dl[i];

        for (genvar j = 0; j < N; j++) begin : g_pe
            assign bus.arr_clear[i*N + j] = first_dl[i + j];
            assign bus.arr_cap[i*N + j]   = last_dl[i + j];
        end
    end

`ifdef SYSTOLIC_SCHED_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= 16'd0;
        else if (accept)
            stall_q <= 16'd0;
        else if (state == FEED && !fire && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign bus.perf_stall = stall_q;
`else
    assign bus.perf_stall = 16'd0;
`endif

    assign bus.a_ready = a_rdy;
    assign bus.b_ready = b_rdy;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_systolic_sched.sv
// Bench for systolic_sched (N=2): table of tiles run back-to-back against a time-keyed
// scoreboard of edge operands/strobes, plus reject, mid-FEED start and reset sequences.
module tb_systolic_sched;
    localparam int N = 2;

    localparam int K_A    = 0;
    localparam int K_B    = 1;
    localparam int K_CLR  = 2;
    localparam int K_CAP  = 3;
    localparam int K_DONE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    systolic_sched_if #(.N(N)) bus();

    systolic_sched #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int kind;
        int idx;
        logic [7:0] val;
    } sb_t;

    sb_t sb[$];

    typedef struct {
        int             k;
        int             stall_at;
        int             stall_len;
        int             stall_kind;   // 1: b_valid low, 2: a_valid low, 3: both low
        bit             start_mid;
        logic [8*N-1:0] a_base;
        logic [8*N-1:0] b_base;
        bit             inc;
        int             done_off;     // start cycle to done cycle
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        logic [8*N-1:0] ea, eb;
        logic [N*N-1:0] ec, ep;
        logic           ed;
        ea = '0; eb = '0; ec = '0; ep = '0; ed = 1'b0;
        for (int q = sb.size() - 1; q >= 0; q--) begin
            if (sb[q].cyc == cyc) begin
                case (sb[q].kind)
                    K_A:     ea[8*sb[q].idx +: 8] = sb[q].val;
                    K_B:     eb[8*sb[q].idx +: 8] = sb[q].val;
                    K_CLR:   ec[sb[q].idx] = 1'b1;
                    K_CAP:   ep[sb[q].idx] = 1'b1;
                    default: ed = 1'b1;
                endcase
                sb.delete(q);
            end else if (sb[q].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_expired: kind %0d idx %0d due cycle %0d never observed", sb[q].kind, sb[q].idx, sb[q].cyc);
                sb.delete(q);
            end
        end
        check("arr_a", bus.arr_a, ea);
        check("arr_b", bus.arr_b, eb);
        check("arr_clear", bus.arr_clear, ec);
        check("arr_cap", bus.arr_cap, ep);
        check("done", bus.done, ed);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic push_beat(input int t, input logic [8*N-1:0] ad, input logic [8*N-1:0] bd,
                             input bit first, input bit last);
        for (int i = 0; i < N; i++) begin
            sb.push_back('{t + 1 + i, K_A, i, ad[8*i +: 8]});
            sb.push_back('{t + 1 + i, K_B, i, bd[8*i +: 8]});
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (first) sb.push_back('{t + 1 + i + j, K_CLR, i*N + j, 8'h01});
                if (last)  sb.push_back('{t + 1 + i + j, K_CAP, i*N + j, 8'h01});
            end
        end
        if (last) sb.push_back('{t + 2*N, K_DONE, 0, 8'h01});
    endtask

    task automatic run_tile(input vec_t v);
        int c0, beat, stall_rem, guard, n;
        logic av, bv;
        logic [8*N-1:0] ad, bd;
        bus.start = 1'b1;
        bus.k_len = 8'(v.k);
        c0 = cyc;
        step();
        bus.start = 1'b0;
        beat = 0;
        stall_rem = v.stall_len;
        guard = 0;
        while (beat < v.k && guard < 200) begin
            guard++;
            av = 1'b1;
            bv = 1'b1;
            if (beat == v.stall_at && stall_rem > 0) begin
                if (v.stall_kind[0]) bv = 1'b0;
                if (v.stall_kind[1]) av = 1'b0;
                stall_rem--;
            end
            for (int i = 0; i < N; i++) begin
                ad[8*i +: 8] = v.a_base[8*i +: 8] + (v.inc ? 8'(beat) : 8'h00);
                bd[8*i +: 8] = v.b_base[8*i +: 8] + (v.inc ? 8'(beat) : 8'h00);
            end
            bus.a_valid = av;
            bus.b_valid = bv;
            bus.a_data  = (av && bv) ? ad : {N{8'hEE}};
            bus.b_data  = (av && bv) ? bd : {N{8'hEE}};
            bus.start   = v.start_mid && (beat == 1);
            bus.k_len   = 8'd1;
            #1;
            check("a_ready", bus.a_ready, bv);
            check("b_ready", bus.b_ready, av);
            check("busy_feed", bus.busy, 1'b1);
            if (av && bv) begin
                push_beat(cyc, ad, bd, beat == 0, beat == v.k - 1);
                beat++;
            end
            step();
            bus.start = 1'b0;
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        check("done_latency", 64'(cyc - c0), 64'(v.done_off));
        check("busy_at_done", bus.busy, 1'b0);
`ifdef SYSTOLIC_SCHED_PERF_EN
        check("perf_stall", bus.perf_stall, 16'(v.stall_len));
`else
        check("perf_stall", bus.perf_stall, 16'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        vecs[0] = '{3, 0, 0, 0, 1'b0, 16'h4038, 16'h3838, 1'b0, 7};
        vecs[1] = '{3, 1, 2, 1, 1'b0, 16'h4038, 16'h3838, 1'b0, 9};
        vecs[2] = '{1, 0, 0, 0, 1'b0, 16'h2211, 16'h4433, 1'b0, 5};
        vecs[3] = '{4, 0, 0, 0, 1'b1, 16'h1020, 16'h3040, 1'b1, 8};
        vecs[4] = '{2, 0, 1, 2, 1'b0, 16'h7705, 16'h0966, 1'b0, 7};
        vecs[5] = '{5, 3, 3, 3, 1'b0, 16'h0181, 16'hA01F, 1'b1, 12};

        bus.start   = 1'b0;
        bus.k_len   = 8'd0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.a_data  = '0;
        bus.b_data  = '0;

        #1;
        check("rst_arr_a", bus.arr_a, '0);
        check("rst_arr_clear", bus.arr_clear, '0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_perf", bus.perf_stall, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Tiles run back-to-back: each start is raised in the cycle done is seen.
        for (int v = 0; v < 6; v++) run_tile(vecs[v]);
        step();

        // Zero-length start is rejected with a single err pulse.
        bus.start = 1'b1;
        bus.k_len = 8'd0;
        step();
        bus.start = 1'b0;
        check("err_pulse", bus.err, 1'b1);
        check("err_busy", bus.busy, 1'b0);
        step();
        check("err_clears", bus.err, 1'b0);
        check("err_busy_after", bus.busy, 1'b0);
        repeat (6) step();

        // Reset mid-FEED abandons the tile.
        bus.start = 1'b1;
        bus.k_len = 8'd6;
        step();
        bus.start   = 1'b0;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            bus.a_data = 16'h5566 + 16'(b);
            bus.b_data = 16'h7788;
            #1;
            push_beat(cyc, bus.a_data, bus.b_data, b == 0, 1'b0);
            step();
        end
        c0 = cyc;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_arr_a", bus.arr_a, '0);
        check("midrst_arr_b", bus.arr_b, '0);
        check("midrst_clear", bus.arr_clear, '0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_a_ready", bus.a_ready, 1'b0);
        check("midrst_b_ready", bus.b_ready, 1'b0);
        sb.delete();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) step();
        check("midrst_idle_busy", bus.busy, 1'b0);
        check("midrst_cycles", 64'(cyc - c0), 64'd10);

        // Design recovers after the abandoned tile.
        run_tile(vecs[2]);
        repeat (3) step();

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_leftover: %0d expected events never observed", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
